adc_capture_ctrl: RTL
=====================

// Module: adc_capture_ctrl
// PURPOSE
//  Sequencer for the LTC2315 ADC interface, in the sck domain.
//  On start_i it releases the interface from reset and collects NUM_SAMPLES good samples.
//  It discards start-bit-error samples and returns the truncated mean with a status code.
//  It then parks the interface in reset to save power.
//  It sits between the ADC interface and the receiver's sample consumer.
// PARAMETERS
//  NUM_SAMPLES     16   good samples per capture; power of 2, 1..256
//  MAX_ERRORS      2    error samples tolerated; reaching it aborts with ERR_LIMIT; 1..15
//  TIMEOUT_CYCLES  128  max sck cycles between adc_valid_i pulses; must be >= 64
// PORTS
//  sck             in   1   ADC serial clock; the only clock
//  rst_n           in   1   asynchronous, active-low reset
//  start_i         in   1   capture request; sampled in IDLE only
//  busy_o          out  1   capture in progress (WAKE/COLLECT/DONE)
//  adc_rst_o       out  1   active-high reset to the ADC interface; 1 = parked
//  adc_data_i      in   12  sample from interface (data_o)
//  adc_valid_i     in   1   sample strobe (valid_o), 1 cycle, every 18 sck
//  adc_error_i     in   1   start-bit error on this sample (error_o); only with valid
//  result_o        out  12  mean of good samples; 0 on abort
//  result_valid_o  out  1   result/status held valid until accepted
//  result_ready_i  in   1   consumer accepts when high with result_valid_o
//  status_o        out  2   00 OK, 01 ERR_LIMIT, 10 TIMEOUT; 11 unused
// BEHAVIOUR
//  Reset: state IDLE, busy_o=0, adc_rst_o=1, result_o=0, result_valid_o=0, status_o=00.
//         All counters and the accumulator are 0. Reset mid-capture aborts silently; no result.
//  IDLE:    adc_rst_o=1. start_i=1 -> WAKE. Clear accumulator, good/err/timeout counters.
//  WAKE:    adc_rst_o=0, busy_o=1. First adc_valid_i is processed as in COLLECT -> COLLECT.
//  COLLECT: on adc_valid_i:
//           adc_error_i=1 -> err_cnt++, sample discarded.
//           Else acc += adc_data_i, good_cnt++.
//           good_cnt reaching NUM_SAMPLES -> DONE, status OK, result_o = acc >> log2(NUM_SAMPLES).
//           err_cnt reaching MAX_ERRORS -> DONE, status ERR_LIMIT, result_o=0.
//  Timeout: counter runs in WAKE/COLLECT, clears on every adc_valid_i.
//           At TIMEOUT_CYCLES -> DONE, status TIMEOUT, result_o=0.
//           A valid in the same cycle as expiry wins; it is processed and no timeout occurs.
//  DONE:    adc_rst_o=1 on entry (next cycle), result_valid_o=1.
//           result_o/status_o stable until result_ready_i=1. Then -> IDLE next cycle.
//           result_valid_o=0 in that cycle.
//  Latency: result_valid_o rises the cycle after the terminating valid, error or timeout.
//  Widths:  accumulator 12+log2(NUM_SAMPLES) bits, never overflows. Mean is truncated, not rounded.
//  Ignored: start_i outside IDLE, including the same cycle as the DONE handshake.
//           adc_valid_i/adc_error_i in IDLE and DONE.
//  adc_error_i without adc_valid_i: ignored.
// CONFIGURATION
//  ADC_CAPTURE_ROUND_EN defined: result_o = (acc + NUM_SAMPLES/2) >> log2(NUM_SAMPLES).
//    Round half up; accumulator gains 1 bit; result saturates at 12'hFFF.
//  ADC_CAPTURE_ROUND_EN undefined: truncating mean as above; no extra logic.
// STRUCTURE
//  adc_pkg holds shared definitions:
//    ADC_BITS=12.
//    typedef enum logic [1:0] {IDLE, WAKE, COLLECT, DONE} adc_cap_state_t.
//    typedef enum logic [1:0] {ST_OK, ST_ERR_LIMIT, ST_TIMEOUT} adc_cap_status_t.
//  Sub-module adc_watchdog: loadable down-counter (TIMEOUT_CYCLES) with clear and expire outputs.
//  FSM, accumulator and counters stay in this module.
// TESTING (bench wires the real ADC interface; NUM_SAMPLES=4, MAX_ERRORS=2)
//  1. miso start bits 0, data 0x100,0x102,0x104,0x106, start_i pulse.
//     -> result_o=0x103, status OK; adc_rst_o=1 after DONE.
//  2. Same data plus one start-bit error sample.
//     -> error skipped, 5 valids consumed, result 0x103, status OK.
//  3. Two error samples before 4 good.
//     -> status ERR_LIMIT, result_o=0, result_valid_o the cycle after the 2nd error.
//  4. Force adc_valid_i=0 after WAKE (interface stuck).
//     -> status TIMEOUT exactly 128 cycles after the last valid; result_o=0.
//  5. Hold result_ready_i=0 for 50 cycles, toggle start_i.
//     -> outputs stable, start ignored; ready=1 -> IDLE. Start then accepted.
//  6. rst_n low mid-COLLECT.
//     -> all outputs at reset values immediately. A new capture gives a correct mean.
//     ROUND_EN build: data 1,2,2,2 -> result 2 (truncated build: 1).

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2315 capture sequencer: sample width, FSM state
// and result status encodings.
package adc_pkg;

  localparam int ADC_BITS = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAKE    = 2'b01,
    COLLECT = 2'b10,
    DONE    = 2'b11
  } adc_cap_state_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_ERR_LIMIT = 2'b01,
    ST_TIMEOUT   = 2'b10
  } adc_cap_status_t;

endpackage

// File: rtl/adc_watchdog.sv
// Reloadable down-counter that flags TIMEOUT_CYCLES cycles of silence since the
// last clear; expire_o is only meaningful while en_i is high.
module adc_watchdog #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  // Loaded with N-1 so expiry is seen in the N-th cycle after the clear edge.
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = LOAD;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= LOAD;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the LTC2315 interface: wakes the ADC, averages NUM_SAMPLES
// good samples, reports status, then parks the ADC. ADC_CAPTURE_ROUND_EN selects a
// round-half-up mean instead of the truncating one.
//
// Result handshake: result_o/status_o are held while result_valid_o is high and
// are consumed on the first cycle with result_valid_o && result_ready_i.
module adc_capture_ctrl
  import adc_pkg::*;
#(
  parameter int NUM_SAMPLES    = 16,
  parameter int MAX_ERRORS     = 2,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                sck,
  input  logic                rst_n,
  input  logic                start_i,
  output logic                busy_o,
  output logic                adc_rst_o,
  input  logic [ADC_BITS-1:0] adc_data_i,
  input  logic                adc_valid_i,
  input  logic                adc_error_i,
  output logic [ADC_BITS-1:0] result_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [1:0]          status_o,
  output adc_cap_state_t      state_o
);

  localparam int LOG2N = $clog2(NUM_SAMPLES);
`ifdef ADC_CAPTURE_ROUND_EN
  localparam int ACC_W = ADC_BITS + LOG2N + 1;
`else
  localparam int ACC_W = ADC_BITS + LOG2N;
`endif
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] GOOD_MAX = CNT_W'(NUM_SAMPLES);
  localparam logic [3:0]       ERR_MAX  = 4'(MAX_ERRORS);

  adc_cap_state_t  state_q, state_d;
  adc_cap_status_t status_q, status_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]    good_q, good_d;
  logic [3:0]          err_q, err_d;
  logic [ADC_BITS-1:0] result_q, result_d, mean;
  logic in_run, wd_expire, good_hit, err_hit, tmo_hit;

  assign in_run = (state_q == WAKE) || (state_q == COLLECT);

  adc_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (sck),
    .rst_n    (rst_n),
    .clear_i  (!in_run || adc_valid_i),
    .en_i     (in_run),
    .expire_o (wd_expire)
  );

  assign acc_sum = acc_q + ACC_W'(adc_data_i);

`ifdef ADC_CAPTURE_ROUND_EN
  logic [ACC_W-1:0] rnd_shift;
  assign rnd_shift = (acc_sum + ACC_W'(NUM_SAMPLES / 2)) >> LOG2N;
  assign mean = (|rnd_shift[ACC_W-1:ADC_BITS]) ? '1 : rnd_shift[ADC_BITS-1:0];
`else
  assign mean = acc_sum[LOG2N +: ADC_BITS];
`endif

  // Datapath: a valid in the expiry cycle is processed and suppresses the timeout.
  always_comb begin
    acc_d    = acc_q;
    good_d   = good_q;
    err_d    = err_q;
    result_d = result_q;
    status_d = status_q;
    good_hit = 1'b0;
    err_hit  = 1'b0;
    tmo_hit  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        acc_d    = '0;
        good_d   = '0;
        err_d    = '0;
        result_d = '0;
        status_d = ST_OK;
      end
    end else if (in_run) begin
      if (adc_valid_i) begin
        if (adc_error_i) begin
          err_d   = err_q + 4'd1;
          err_hit = (err_d == ERR_MAX);
        end else begin
          acc_d    = acc_sum;
          good_d   = good_q + CNT_W'(1);
          good_hit = (good_d == GOOD_MAX);
        end
      end else begin
        tmo_hit = wd_expire;
      end
      if (good_hit) begin
        result_d = mean;
        status_d = ST_OK;
      end else if (err_hit) begin
        result_d = '0;
        status_d = ST_ERR_LIMIT;
      end else if (tmo_hit) begin
        result_d = '0;
        status_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      good_q   <= '0;
      err_q    <= '0;
      result_q <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      good_q   <= good_d;
      err_q    <= err_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = WAKE;
      WAKE: begin
        if (good_hit || err_hit || tmo_hit) state_d = DONE;
        else if (adc_valid_i)               state_d = COLLECT;
      end
      COLLECT: if (good_hit || err_hit || tmo_hit) state_d = DONE;
      DONE:    if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != IDLE);
    adc_rst_o      = (state_q == IDLE) || (state_q == DONE);
    result_valid_o = (state_q == DONE);
  end

  assign result_o = result_q;
  assign status_o = status_q;
  assign state_o  = state_q;

endmodule
